dma_axi_to_reg: RTL and testbench

DMA_AXI_TO_REG -- requirements
Module: dma_axi_to_reg

---
 rtl/dma_axi_to_reg_pkg.sv | 91 +++++++++
 rtl/dma_axi_to_reg_if.sv | 19 +
 rtl/dma_axi_to_reg.sv | 199 +++++++++++++++++++
 tb/tb_dma_axi_to_reg.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_axi_to_reg_pkg.sv
// Shared types for the AXI-to-register DMA frontend bridge.
// Provides the AXI channel structs (request/response bundles), the
// register-interface request/response structs and the AXI encodings.
// Widths are fixed here: 32-bit address, 4-bit ID, 64-bit data
// (ByteWidthInPowersOfTwo = 3), 8-bit burst length.
package dma_axi_to_reg_pkg;

  typedef logic [2:0] size_t;
  typedef logic [1:0] burst_t;
  typedef logic [1:0] resp_t;

  localparam burst_t BURST_FIXED = 2'b00;
  localparam burst_t BURST_INCR  = 2'b01;
  localparam burst_t BURST_WRAP  = 2'b10;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_SLVERR = 2'b10;

  localparam int unsigned AddrWidth = 32;
  localparam int unsigned DataWidth = 64;
  localparam int unsigned StrbWidth = DataWidth / 8;
  localparam int unsigned IdWidth   = 4;

  typedef logic [AddrWidth-1:0] addr_t;
  typedef logic [DataWidth-1:0] data_t;
  typedef logic [StrbWidth-1:0] strb_t;
  typedef logic [IdWidth-1:0]   id_t;
  typedef logic [7:0]           len_t;

  typedef struct packed {
    id_t    id;
    addr_t  addr;
    len_t   len;
    size_t  size;
    burst_t burst;
  } ax_chan_t;

  typedef struct packed {
    data_t data;
    strb_t strb;
    logic  last;
  } w_chan_t;

  typedef struct packed {
    id_t   id;
    resp_t resp;
  } b_chan_t;

  typedef struct packed {
    id_t   id;
    data_t data;
    resp_t resp;
    logic  last;
  } r_chan_t;

  typedef struct packed {
    ax_chan_t aw;
    logic     aw_valid;
    w_chan_t  w;
    logic     w_valid;
    logic     b_ready;
    ax_chan_t ar;
    logic     ar_valid;
    logic     r_ready;
  } axi_req_t;

  typedef struct packed {
    logic    aw_ready;
    logic    ar_ready;
    logic    w_ready;
    logic    b_valid;
    b_chan_t b;
    logic    r_valid;
    r_chan_t r;
  } axi_rsp_t;

  typedef struct packed {
    addr_t addr;
    logic  write;
    data_t wdata;
    strb_t wstrb;
    logic  valid;
  } reg_req_t;

  typedef struct packed {
    data_t rdata;
    logic  error;
    logic  ready;
  } reg_rsp_t;

endpackage

// File: rtl/dma_axi_to_reg_if.sv
// Bundle of the bridge's bus-side signals.
//   axi_req / axi_rsp : AXI request/response pair (manager drives axi_req)
//   reg_req / reg_rsp : register request/response pair (bridge drives reg_req)
// Modports: master/slave for the AXI side, reg_master/reg_slave for the
// register side.
interface dma_axi_to_reg_if;
  import dma_axi_to_reg_pkg::*;

  axi_req_t axi_req;
  axi_rsp_t axi_rsp;
  reg_req_t reg_req;
  reg_rsp_t reg_rsp;

  modport master     (output axi_req, input  axi_rsp);
  modport slave      (input  axi_req, output axi_rsp);
  modport reg_master (output reg_req, input  reg_rsp);
  modport reg_slave  (input  reg_req, output reg_rsp);

endinterface

// File: rtl/dma_axi_to_reg.sv
// AXI subordinate to register-interface bridge for the DMA frontend.
// One transaction in flight; each AXI beat becomes one register access.
// Ports:
//   clk_i     - clock
//   rst_ni    - asynchronous active-low reset
//   axi_req_i - AXI request (AW/W/AR channels, B/R ready)
//   axi_rsp_o - AXI response (AW/W/AR ready, B/R channels)
//   reg_req_o - register request (addr, write, wdata, wstrb, valid)
//   reg_rsp_i - register response (rdata, error, ready)
module dma_axi_to_reg #(
  parameter type axi_req_t = dma_axi_to_reg_pkg::axi_req_t,
  parameter type axi_rsp_t = dma_axi_to_reg_pkg::axi_rsp_t,
  parameter type reg_req_t = dma_axi_to_reg_pkg::reg_req_t,
  parameter type reg_rsp_t = dma_axi_to_reg_pkg::reg_rsp_t,
  parameter dma_axi_to_reg_pkg::size_t ByteWidthInPowersOfTwo = dma_axi_to_reg_pkg::size_t'(3)
) (
  input  logic     clk_i,
  input  logic     rst_ni,
  input  axi_req_t axi_req_i,
  output axi_rsp_t axi_rsp_o,
  output reg_req_t reg_req_o,
  input  reg_rsp_t reg_rsp_i
);
  import dma_axi_to_reg_pkg::*;

  typedef enum logic [2:0] {
    IDLE,
    WR_DATA,
    WR_REG,
    WR_RESP,
    RD_REG,
    RD_RESP
  } state_e;

  localparam addr_t BeatBytes = addr_t'(1) << ByteWidthInPowersOfTwo;

  state_e state_q;
  id_t    id_q;
  addr_t  addr_q;
  burst_t burst_q;
  len_t   cnt_q;
  data_t  wdata_q;
  strb_t  wstrb_q;
  data_t  rdata_q;
  logic   rerr_q;
  logic   err_q;
  logic   last_wr_q;

  logic  grant_wr;
  logic  grant_rd;
  logic  tie;
  addr_t addr_next;

  // last_wr_q only moves on contention, so a lone request never
  // disturbs the tie-break order.
  assign tie       = axi_req_i.aw_valid && axi_req_i.ar_valid;
  assign grant_wr  = axi_req_i.aw_valid && (!axi_req_i.ar_valid || !last_wr_q);
  assign grant_rd  = axi_req_i.ar_valid && !grant_wr;
  assign addr_next = (burst_q == BURST_FIXED) ? addr_q : addr_q + BeatBytes;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      id_q      <= '0;
      addr_q    <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      rdata_q   <= '0;
      rerr_q    <= 1'b0;
      err_q     <= 1'b0;
      last_wr_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (grant_wr) begin
            id_q    <= axi_req_i.aw.id;
            addr_q  <= axi_req_i.aw.addr;
            cnt_q   <= axi_req_i.aw.len;
            burst_q <= axi_req_i.aw.burst;
            err_q   <= 1'b0;
            state_q <= WR_DATA;
            if (tie) last_wr_q <= 1'b1;
          end else if (grant_rd) begin
            id_q    <= axi_req_i.ar.id;
            addr_q  <= axi_req_i.ar.addr;
            cnt_q   <= axi_req_i.ar.len;
            burst_q <= axi_req_i.ar.burst;
            state_q <= RD_REG;
            if (tie) last_wr_q <= 1'b0;
          end
        end
        WR_DATA: begin
          if (axi_req_i.w_valid) begin
            wdata_q <= axi_req_i.w.data;
            wstrb_q <= axi_req_i.w.strb;
            state_q <= WR_REG;
          end
        end
        WR_REG: begin
          if (reg_rsp_i.ready) begin
            err_q <= err_q | reg_rsp_i.error;
            if (cnt_q == '0) begin
              state_q <= WR_RESP;
            end else begin
              cnt_q   <= cnt_q - len_t'(1);
              addr_q  <= addr_next;
              state_q <= WR_DATA;
            end
          end
        end
        WR_RESP: begin
          if (axi_req_i.b_ready) begin
            err_q   <= 1'b0;
            state_q <= IDLE;
          end
        end
        RD_REG: begin
          if (reg_rsp_i.ready) begin
            rdata_q <= reg_rsp_i.rdata;
            rerr_q  <= reg_rsp_i.error;
            state_q <= RD_RESP;
          end
        end
        RD_RESP: begin
          if (axi_req_i.r_ready) begin
            if (cnt_q == '0) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q - len_t'(1);
              addr_q  <= addr_next;
              state_q <= RD_REG;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Outputs decode from registered state only; the IDLE readies are the
  // exception and are gated by reset so nothing is accepted while it is held.
  always_comb begin
    axi_rsp_o = '0;
    reg_req_o = '0;
    case (state_q)
      IDLE: begin
        if (rst_ni) begin
          axi_rsp_o.aw_ready = grant_wr;
          axi_rsp_o.ar_ready = grant_rd;
        end
      end
      WR_DATA: axi_rsp_o.w_ready = 1'b1;
      WR_REG, RD_REG: begin
        reg_req_o.valid = 1'b1;
        reg_req_o.write = (state_q == WR_REG);
        reg_req_o.addr  = addr_q;
        reg_req_o.wdata = wdata_q;
        reg_req_o.wstrb = wstrb_q;
      end
      WR_RESP: begin
        axi_rsp_o.b_valid = 1'b1;
        axi_rsp_o.b.id    = id_q;
        axi_rsp_o.b.resp  = err_q ? RESP_SLVERR : RESP_OKAY;
      end
      RD_RESP: begin
        axi_rsp_o.r_valid = 1'b1;
        axi_rsp_o.r.id    = id_q;
        axi_rsp_o.r.data  = rdata_q;
        axi_rsp_o.r.resp  = rerr_q ? RESP_SLVERR : RESP_OKAY;
        axi_rsp_o.r.last  = (cnt_q == '0);
      end
      default: ;
    endcase
  end

  // Unsupported request shapes: narrow/wide beats and WRAP bursts are not
  // handled; W.last must line up with the beat counter.
  always_ff @(posedge clk_i) begin
    if (rst_ni && state_q == IDLE && axi_req_i.aw_valid) begin
      assert (axi_req_i.aw.size == ByteWidthInPowersOfTwo)
        else $error("aw.size %0d unsupported", axi_req_i.aw.size);
      assert (axi_req_i.aw.burst != BURST_WRAP)
        else $error("aw WRAP burst unsupported");
    end
    if (rst_ni && state_q == IDLE && axi_req_i.ar_valid) begin
      assert (axi_req_i.ar.size == ByteWidthInPowersOfTwo)
        else $error("ar.size %0d unsupported", axi_req_i.ar.size);
      assert (axi_req_i.ar.burst != BURST_WRAP)
        else $error("ar WRAP burst unsupported");
    end
    if (rst_ni && state_q == WR_DATA && axi_req_i.w_valid) begin
      assert (axi_req_i.w.last == (cnt_q == '0))
        else $error("w.last does not match burst length");
    end
  end

endmodule

// File: tb/tb_dma_axi_to_reg.sv
// Directed bench for dma_axi_to_reg: single/burst writes and reads,
// register wait states and errors, FIXED and wrapping-address bursts,
// AW/AR contention order, and reset in the middle of a read response.
module tb_dma_axi_to_reg;
  import dma_axi_to_reg_pkg::*;

  localparam int unsigned S_AW  = 0;
  localparam int unsigned S_AR  = 1;
  localparam int unsigned S_W   = 2;
  localparam int unsigned S_B   = 3;
  localparam int unsigned S_R   = 4;
  localparam int unsigned S_REG = 5;

  typedef struct {
    addr_t addr;
    logic  write;
    data_t wdata;
    strb_t wstrb;
  } exp_reg_t;

  typedef struct {
    id_t   id;
    resp_t resp;
    data_t data;
    logic  last;
  } exp_rsp_t;

  logic        clk_i;
  logic        rst_ni;
  int unsigned cyc;
  int          checks;
  int          errors;

  exp_reg_t exp_reg_q[$];
  exp_rsp_t exp_b_q[$];
  exp_rsp_t exp_r_q[$];

  dma_axi_to_reg_if bus ();

  dma_axi_to_reg #(
    .axi_req_t             (axi_req_t),
    .axi_rsp_t             (axi_rsp_t),
    .reg_req_t             (reg_req_t),
    .reg_rsp_t             (reg_rsp_t),
    .ByteWidthInPowersOfTwo(size_t'(3))
  ) dut (
    .clk_i    (clk_i),
    .rst_ni   (rst_ni),
    .axi_req_i(bus.axi_req),
    .axi_rsp_o(bus.axi_rsp),
    .reg_req_o(bus.reg_req),
    .reg_rsp_i(bus.reg_rsp)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  initial cyc = 0;
  always @(posedge clk_i) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog observed=running required=finished");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  function automatic bit sig(input int unsigned which);
    case (which)
      S_AW:    return bus.axi_rsp.aw_ready;
      S_AR:    return bus.axi_rsp.ar_ready;
      S_W:     return bus.axi_rsp.w_ready;
      S_B:     return bus.axi_rsp.b_valid;
      S_R:     return bus.axi_rsp.r_valid;
      default: return bus.reg_req.valid;
    endcase
  endfunction

  // Called just after a falling edge; returns 1 time unit after the falling
  // edge at which the signal is seen high.
  task automatic wait_sig(input int unsigned which, input string tag);
    bit ok;
    ok = 1'b0;
    for (int n = 0; n < 64; n++) begin
      #1;
      if (sig(which)) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk_i);
    end
    chk({tag, "_timeout"}, ok, 1'b1);
  endtask

  task automatic ax_drive(input bit is_wr, input id_t id, input addr_t addr, input len_t len,
                          input burst_t burst);
    ax_chan_t c;
    c.id    = id;
    c.addr  = addr;
    c.len   = len;
    c.size  = size_t'(3);
    c.burst = burst;
    if (is_wr) begin
      bus.axi_req.aw       = c;
      bus.axi_req.aw_valid = 1'b1;
    end else begin
      bus.axi_req.ar       = c;
      bus.axi_req.ar_valid = 1'b1;
    end
  endtask

  task automatic ax_accept(input bit is_wr, output int unsigned t);
    wait_sig(is_wr ? S_AW : S_AR, is_wr ? "aw_ready" : "ar_ready");
    t = cyc;
    @(negedge clk_i);
    if (is_wr) bus.axi_req.aw_valid = 1'b0;
    else       bus.axi_req.ar_valid = 1'b0;
  endtask

  task automatic reg_serve(input bit is_wr, input int unsigned rwait, input logic err,
                           input data_t rdata);
    exp_reg_t e;
    wait_sig(S_REG, "reg_valid");
    e = exp_reg_q.pop_front();
    chk("reg_addr", bus.reg_req.addr, e.addr);
    chk("reg_write", bus.reg_req.write, e.write);
    if (is_wr) begin
      chk("reg_wdata", bus.reg_req.wdata, e.wdata);
      chk("reg_wstrb", bus.reg_req.wstrb, e.wstrb);
    end
    for (int k = 0; k < int'(rwait); k++) begin
      @(negedge clk_i);
      #1;
      chk("reg_hold_valid", bus.reg_req.valid, 1'b1);
      chk("reg_hold_addr", bus.reg_req.addr, e.addr);
    end
    bus.reg_rsp.ready = 1'b1;
    bus.reg_rsp.error = err;
    bus.reg_rsp.rdata = rdata;
    @(negedge clk_i);
    bus.reg_rsp = '0;
  endtask

  task automatic w_phase(input id_t id, input addr_t addr, input len_t len, input burst_t burst,
                         input data_t d0, input strb_t strb, input logic [3:0] err,
                         input int unsigned rwait, input bit lat_on, input int unsigned t0);
    exp_reg_t er;
    exp_rsp_t ep;
    logic     any_err;
    logic     e;
    any_err = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      bus.axi_req.w.data  = d0 + data_t'(i);
      bus.axi_req.w.strb  = strb;
      bus.axi_req.w.last  = (i == int'(len));
      bus.axi_req.w_valid = 1'b1;
      er.addr  = (burst == BURST_FIXED) ? addr : addr + addr_t'(i * 8);
      er.write = 1'b1;
      er.wdata = d0 + data_t'(i);
      er.wstrb = strb;
      exp_reg_q.push_back(er);
      wait_sig(S_W, "w_ready");
      chk("reg_idle_in_wdata", bus.reg_req.valid, 1'b0);
      @(negedge clk_i);
      bus.axi_req.w_valid = 1'b0;
      e = (i < 4) ? err[i] : 1'b0;
      any_err = any_err | e;
      reg_serve(1'b1, rwait, e, '0);
    end
    ep.id   = id;
    ep.resp = any_err ? RESP_SLVERR : RESP_OKAY;
    ep.data = '0;
    ep.last = 1'b1;
    exp_b_q.push_back(ep);
    wait_sig(S_B, "b_valid");
    if (lat_on) chk("b_latency", cyc - t0, 3);
    ep = exp_b_q.pop_front();
    chk("b_id", bus.axi_rsp.b.id, ep.id);
    chk("b_resp", bus.axi_rsp.b.resp, ep.resp);
    chk("reg_idle_in_bresp", bus.reg_req.valid, 1'b0);
    bus.axi_req.b_ready = 1'b1;
    @(negedge clk_i);
    bus.axi_req.b_ready = 1'b0;
  endtask

  task automatic r_phase(input id_t id, input addr_t addr, input len_t len, input burst_t burst,
                         input data_t d0, input logic [3:0] err, input bit lat_on,
                         input int unsigned t0);
    exp_reg_t er;
    exp_rsp_t ep;
    logic     e;
    for (int i = 0; i <= int'(len); i++) begin
      er.addr  = (burst == BURST_FIXED) ? addr : addr + addr_t'(i * 8);
      er.write = 1'b0;
      er.wdata = '0;
      er.wstrb = '0;
      exp_reg_q.push_back(er);
      e = (i < 4) ? err[i] : 1'b0;
      ep.id   = id;
      ep.data = d0 + data_t'(i);
      ep.resp = e ? RESP_SLVERR : RESP_OKAY;
      ep.last = (i == int'(len));
      exp_r_q.push_back(ep);
      reg_serve(1'b0, 0, e, d0 + data_t'(i));
      wait_sig(S_R, "r_valid");
      if (lat_on && i == 0) chk("r_latency", cyc - t0, 2);
      ep = exp_r_q.pop_front();
      chk("r_data", bus.axi_rsp.r.data, ep.data);
      chk("r_id", bus.axi_rsp.r.id, ep.id);
      chk("r_resp", bus.axi_rsp.r.resp, ep.resp);
      chk("r_last", bus.axi_rsp.r.last, ep.last);
      chk("reg_idle_in_rresp", bus.reg_req.valid, 1'b0);
      bus.axi_req.r_ready = 1'b1;
      @(negedge clk_i);
      bus.axi_req.r_ready = 1'b0;
    end
  endtask

  task automatic tie_pair(input bit wr_first, input id_t id, input addr_t base);
    int unsigned t;
    ax_drive(1'b1, id, base, 8'd0, BURST_INCR);
    ax_drive(1'b0, id_t'(id + 1), base + 32'h80, 8'd0, BURST_INCR);
    #1;
    chk("tie_aw_ready", bus.axi_rsp.aw_ready, wr_first);
    chk("tie_ar_ready", bus.axi_rsp.ar_ready, !wr_first);
    if (wr_first) begin
      ax_accept(1'b1, t);
      w_phase(id, base, 8'd0, BURST_INCR, 64'h7700 + data_t'(base), 8'h0F, 4'b0, 0, 1'b0, t);
      ax_accept(1'b0, t);
      r_phase(id_t'(id + 1), base + 32'h80, 8'd0, BURST_INCR, 64'h5500, 4'b0, 1'b0, t);
    end else begin
      ax_accept(1'b0, t);
      r_phase(id_t'(id + 1), base + 32'h80, 8'd0, BURST_INCR, 64'h5500, 4'b0, 1'b0, t);
      ax_accept(1'b1, t);
      w_phase(id, base, 8'd0, BURST_INCR, 64'h7700 + data_t'(base), 8'h0F, 4'b0, 0, 1'b0, t);
    end
  endtask

  task automatic idle_outputs(input string tag);
    chk({tag, "_aw_ready"}, bus.axi_rsp.aw_ready, 1'b0);
    chk({tag, "_ar_ready"}, bus.axi_rsp.ar_ready, 1'b0);
    chk({tag, "_w_ready"}, bus.axi_rsp.w_ready, 1'b0);
    chk({tag, "_b_valid"}, bus.axi_rsp.b_valid, 1'b0);
    chk({tag, "_r_valid"}, bus.axi_rsp.r_valid, 1'b0);
    chk({tag, "_reg_valid"}, bus.reg_req.valid, 1'b0);
  endtask

  initial begin
    int unsigned t;
    checks = 0;
    errors = 0;
    rst_ni = 1'b0;
    bus.axi_req = '0;
    bus.reg_rsp = '0;

    // Reset: everything quiet, even with requests pending
    repeat (2) @(negedge clk_i);
    #1;
    idle_outputs("rst");
    ax_drive(1'b1, 4'h1, 32'h0, 8'd0, BURST_INCR);
    ax_drive(1'b0, 4'h2, 32'h0, 8'd0, BURST_INCR);
    #1;
    chk("rst_req_aw_ready", bus.axi_rsp.aw_ready, 1'b0);
    chk("rst_req_ar_ready", bus.axi_rsp.ar_ready, 1'b0);
    @(negedge clk_i);
    bus.axi_req = '0;
    rst_ni = 1'b1;
    #1;
    idle_outputs("post_rst");
    @(negedge clk_i);

    // Single write 0x40 / 0xDEADBEEF, zero-wait register
    ax_drive(1'b1, 4'h3, 32'h40, 8'd0, BURST_INCR);
    ax_accept(1'b1, t);
    w_phase(4'h3, 32'h40, 8'd0, BURST_INCR, 64'hDEAD_BEEF, 8'hFF, 4'b0, 0, 1'b1, t);

    // Single read with minimum latency
    ax_drive(1'b0, 4'h9, 32'h80, 8'd0, BURST_INCR);
    ax_accept(1'b0, t);
    r_phase(4'h9, 32'h80, 8'd0, BURST_INCR, 64'h1234_5678_9ABC_DEF0, 4'b0, 1'b1, t);

    // Read burst len=3 at 0x100
    ax_drive(1'b0, 4'h4, 32'h100, 8'd3, BURST_INCR);
    ax_accept(1'b0, t);
    r_phase(4'h4, 32'h100, 8'd3, BURST_INCR, 64'hCAFE_0000, 4'b0, 1'b0, t);

    // Write burst len=3 with two register wait states per beat
    ax_drive(1'b1, 4'h7, 32'h2000, 8'd3, BURST_INCR);
    ax_accept(1'b1, t);
    w_phase(4'h7, 32'h2000, 8'd3, BURST_INCR, 64'h1111_0000, 8'h3C, 4'b0, 2, 1'b0, t);

    // Write burst len=1, register error on beat 0
    ax_drive(1'b1, 4'hA, 32'h500, 8'd1, BURST_INCR);
    ax_accept(1'b1, t);
    w_phase(4'hA, 32'h500, 8'd1, BURST_INCR, 64'hBAD0, 8'hFF, 4'b0001, 0, 1'b0, t);

    // FIXED write len=2 and FIXED read len=1 with error on second beat
    ax_drive(1'b1, 4'hB, 32'h200, 8'd2, BURST_FIXED);
    ax_accept(1'b1, t);
    w_phase(4'hB, 32'h200, 8'd2, BURST_FIXED, 64'h2220, 8'h01, 4'b0, 1, 1'b0, t);
    ax_drive(1'b0, 4'hC, 32'h208, 8'd1, BURST_FIXED);
    ax_accept(1'b0, t);
    r_phase(4'hC, 32'h208, 8'd1, BURST_FIXED, 64'h3330, 4'b0010, 1'b0, t);

    // INCR read across the top of the address space
    ax_drive(1'b0, 4'hD, 32'hFFFF_FFF8, 8'd1, BURST_INCR);
    ax_accept(1'b0, t);
    r_phase(4'hD, 32'hFFFF_FFF8, 8'd1, BURST_INCR, 64'h4440, 4'b0, 1'b0, t);

    // Longest burst: len=255 gives 256 beats
    ax_drive(1'b0, 4'hE, 32'h1_0000, 8'd255, BURST_INCR);
    ax_accept(1'b0, t);
    r_phase(4'hE, 32'h1_0000, 8'd255, BURST_INCR, 64'h9000, 4'b0, 1'b0, t);

    // Contention: write first, then read first, then write first again
    tie_pair(1'b1, 4'h2, 32'h3000);
    tie_pair(1'b0, 4'h4, 32'h3100);
    tie_pair(1'b1, 4'h6, 32'h3200);

    // Reset while a read response is waiting on r_ready
    ax_drive(1'b0, 4'h5, 32'h600, 8'd0, BURST_INCR);
    ax_accept(1'b0, t);
    begin
      exp_reg_t er;
      er.addr  = 32'h600;
      er.write = 1'b0;
      er.wdata = '0;
      er.wstrb = '0;
      exp_reg_q.push_back(er);
    end
    reg_serve(1'b0, 0, 1'b0, 64'h6666);
    wait_sig(S_R, "pre_rst_r_valid");
    @(negedge clk_i);
    #1;
    chk("stall_r_valid", bus.axi_rsp.r_valid, 1'b1);
    rst_ni = 1'b0;
    #1;
    idle_outputs("mid_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk_i);
      #1;
      chk("no_stale_r", bus.axi_rsp.r_valid, 1'b0);
      chk("no_stale_b", bus.axi_rsp.b_valid, 1'b0);
      chk("no_stale_reg", bus.reg_req.valid, 1'b0);
    end
    @(negedge clk_i);

    // Reset restored the tie-break to favour the write
    tie_pair(1'b1, 4'h8, 32'h3300);

    repeat (2) @(negedge clk_i);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
